// File: rtl/udp_receive.sv
// GMII receive path: parses Ethernet/IPv4/UDP, filters on local MAC/IP/port,
// checks IP header checksum and FCS, and writes the UDP payload as 32-bit words.
module udp_receive #(
  parameter logic [47:0] LOCAL_MAC  = 48'h000A3501FEC0,
  parameter logic [31:0] LOCAL_IP   = 32'hC0A80002,
  parameter logic [15:0] LOCAL_PORT = 16'h1F90
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rxdv,
  input  logic        i_rxer,
  input  logic [7:0]  i_datain,
  output logic        o_ram_wr_en,
  output logic [7:0]  o_ram_wr_addr,
  output logic [31:0] o_ram_wr_data,
  output logic [15:0] o_rx_data_length,
  output logic        o_rx_done,
  output logic        o_rx_err,
  output logic [3:0]  o_rx_state
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_PRE  = 4'd1,
    S_MAC  = 4'd2,
    S_IP   = 4'd3,
    S_UDP  = 4'd4,
    S_DATA = 4'd5,
    S_WAIT = 4'd6,
    S_DROP = 4'd7
  } state_t;

  state_t      r_state, w_nstate;
  logic [15:0] r_cnt;
  logic        r_armed;
  logic        r_mac_loc, r_mac_bc;
  logic [7:0]  r_hi;
  logic [19:0] r_csum;
  logic [15:0] r_len;
  logic [23:0] r_shift;
  logic [31:0] r_crc;
  logic        r_wr_en;
  logic [7:0]  r_wr_addr;
  logic [31:0] r_wr_data;
  logic        r_done, r_err;

  logic        w_wr, w_done, w_err, w_crc_init;
  logic [31:0] w_wr_data;
  logic [7:0]  w_mac_byte, w_ip_byte;
  logic        w_loc, w_bc, w_last;
  logic [15:0] w_len;
  logic [19:0] w_sum;
  logic [16:0] w_fold1;
  logic [15:0] w_fold2;

  // Reflected CRC-32, one byte, LSB first, no final inversion.
  function automatic logic [31:0] f_crc8(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  always_comb begin
    w_mac_byte = LOCAL_MAC[7:0];
    case (r_cnt[2:0])
      3'd0:    w_mac_byte = LOCAL_MAC[47:40];
      3'd1:    w_mac_byte = LOCAL_MAC[39:32];
      3'd2:    w_mac_byte = LOCAL_MAC[31:24];
      3'd3:    w_mac_byte = LOCAL_MAC[23:16];
      3'd4:    w_mac_byte = LOCAL_MAC[15:8];
      default: w_mac_byte = LOCAL_MAC[7:0];
    endcase
    w_ip_byte = LOCAL_IP[7:0];
    case (r_cnt[1:0])
      2'd0:    w_ip_byte = LOCAL_IP[31:24];
      2'd1:    w_ip_byte = LOCAL_IP[23:16];
      2'd2:    w_ip_byte = LOCAL_IP[15:8];
      default: w_ip_byte = LOCAL_IP[7:0];
    endcase
  end

  assign w_loc   = r_mac_loc && (i_datain == w_mac_byte);
  assign w_bc    = r_mac_bc && (i_datain == 8'hFF);
  assign w_len   = {r_hi, i_datain};
  assign w_sum   = r_csum + {4'h0, r_hi, i_datain};
  assign w_fold1 = {1'b0, w_sum[15:0]} + {13'h0, w_sum[19:16]};
  assign w_fold2 = w_fold1[15:0] + {15'h0, w_fold1[16]};
  assign w_last  = (r_cnt == r_len - 16'd9);

  always_comb begin
    w_nstate   = r_state;
    w_wr       = 1'b0;
    w_wr_data  = r_wr_data;
    w_done     = 1'b0;
    w_err      = 1'b0;
    w_crc_init = 1'b0;
    case (r_state)
      S_IDLE:
        if (r_armed && i_rxdv && i_datain == 8'h55) w_nstate = S_PRE;
      S_PRE:
        if (!i_rxdv) w_nstate = S_IDLE;
        else if (i_rxer) w_nstate = S_DROP;
        else if (i_datain == 8'hD5) begin
          w_nstate   = S_MAC;
          w_crc_init = 1'b1;
        end
        // r_cnt counts 55s after the one seen in IDLE; an eighth one is too many
        else if (i_datain != 8'h55 || r_cnt >= 16'd6) w_nstate = S_DROP;
      S_MAC:
        if (!i_rxdv) w_nstate = S_IDLE;
        else if (i_rxer) w_nstate = S_DROP;
        else if (r_cnt < 16'd6 && !w_loc && !w_bc) w_nstate = S_DROP;
        else if (r_cnt == 16'd12 && i_datain != 8'h08) w_nstate = S_DROP;
        else if (r_cnt == 16'd13) w_nstate = (i_datain == 8'h00) ? S_IP : S_DROP;
      S_IP:
        if (!i_rxdv) w_nstate = S_IDLE;
        else if (i_rxer) w_nstate = S_DROP;
        else if ((r_cnt == 16'd0 && i_datain != 8'h45) ||
                 (r_cnt == 16'd9 && i_datain != 8'h11) ||
                 (r_cnt >= 16'd16 && i_datain != w_ip_byte)) w_nstate = S_DROP;
        else if (r_cnt == 16'd19) w_nstate = (w_fold2 == 16'hFFFF) ? S_UDP : S_DROP;
      S_UDP:
        if (!i_rxdv) begin
          w_nstate = S_IDLE;
          w_err    = 1'b1;
        end else if (i_rxer) begin
          w_nstate = S_DROP;
          w_err    = 1'b1;
        end else if ((r_cnt == 16'd2 && i_datain != LOCAL_PORT[15:8]) ||
                     (r_cnt == 16'd3 && i_datain != LOCAL_PORT[7:0]) ||
                     (r_cnt == 16'd5 && w_len < 16'd8)) w_nstate = S_DROP;
        else if (r_cnt == 16'd7) w_nstate = (r_len == 16'd8) ? S_WAIT : S_DATA;
      S_DATA:
        if (!i_rxdv) begin
          w_nstate = S_IDLE;
          w_err    = 1'b1;
        end else if (i_rxer) begin
          w_nstate = S_DROP;
          w_err    = 1'b1;
        end else begin
          if (r_cnt[1:0] == 2'd3) begin
            w_wr      = 1'b1;
            w_wr_data = {r_shift, i_datain};
          end else if (w_last) begin
            w_wr = 1'b1;
            case (r_cnt[1:0])
              2'd0:    w_wr_data = {i_datain, 24'h0};
              2'd1:    w_wr_data = {r_shift[7:0], i_datain, 16'h0};
              default: w_wr_data = {r_shift[15:0], i_datain, 8'h0};
            endcase
          end
          if (w_last) w_nstate = S_WAIT;
        end
      S_WAIT:
        if (!i_rxdv) begin
          w_nstate = S_IDLE;
          // residue of a frame whose appended FCS is correct
          if (r_crc == 32'hDEBB20E3) w_done = 1'b1;
          else w_err = 1'b1;
        end else if (i_rxer) begin
          w_nstate = S_DROP;
          w_err    = 1'b1;
        end
      S_DROP:
        if (!i_rxdv) w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 16'd0;
      r_armed   <= 1'b0;
      r_mac_loc <= 1'b0;
      r_mac_bc  <= 1'b0;
      r_hi      <= 8'h0;
      r_csum    <= 20'h0;
      r_len     <= 16'h0;
      r_shift   <= 24'h0;
      r_crc     <= 32'hFFFFFFFF;
      r_wr_en   <= 1'b0;
      r_wr_addr <= 8'h0;
      r_wr_data <= 32'h0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= (w_nstate != r_state) ? 16'd0 : r_cnt + 16'd1;
      // a frame cut by reset must finish (rxdv low) before a new one is accepted
      if (!i_rxdv) r_armed <= 1'b1;
      if (w_crc_init) begin
        r_crc     <= 32'hFFFFFFFF;
        r_mac_loc <= 1'b1;
        r_mac_bc  <= 1'b1;
        r_csum    <= 20'h0;
        r_wr_addr <= 8'h0;
      end else begin
        if (i_rxdv && r_state inside {S_MAC, S_IP, S_UDP, S_DATA, S_WAIT})
          r_crc <= f_crc8(r_crc, i_datain);
        if (r_state == S_MAC && r_cnt < 16'd6) begin
          r_mac_loc <= w_loc;
          r_mac_bc  <= w_bc;
        end
        if (r_state == S_IP) begin
          if (!r_cnt[0]) r_hi <= i_datain;
          else r_csum <= w_sum;
        end
        if (r_wr_en) r_wr_addr <= r_wr_addr + 8'd1;
      end
      if (r_state == S_UDP && r_cnt == 16'd4) r_hi <= i_datain;
      if (r_state == S_UDP && r_cnt == 16'd5 && i_rxdv && !i_rxer && w_len >= 16'd8)
        r_len <= w_len;
      if (r_state == S_DATA) r_shift <= {r_shift[15:0], i_datain};
      r_wr_en <= w_wr;
      if (w_wr) r_wr_data <= w_wr_data;
      r_done <= w_done;
      r_err  <= w_err;
    end
  end

  assign o_ram_wr_en      = r_wr_en;
  assign o_ram_wr_addr    = r_wr_addr;
  assign o_ram_wr_data    = r_wr_data;
  assign o_rx_data_length = r_len;
  assign o_rx_done        = r_done;
  assign o_rx_err         = r_err;
  assign o_rx_state       = r_state;

endmodule

// File: doc/udp_receive.md
# udp_receive

GMII receive-side counterpart of the board's UDP packet transmitter. It parses incoming Ethernet/IPv4/UDP frames and filters them on local MAC (or broadcast), local IP and local UDP port. It checks the IPv4 header checksum and the Ethernet FCS, and writes the UDP payload as big-endian 32-bit words into the same 256-word dual-port RAM the transmit path reads from.

## Interface
- LOCAL_MAC, 48'h000A3501FEC0, accepted destination MAC (FF-FF-FF-FF-FF-FF is also accepted)
- LOCAL_IP, 32'hC0A80002, accepted destination IPv4 address
- LOCAL_PORT, 16'h1F90, accepted UDP destination port
- clk  input  1  GMII RX clock; all logic on the rising edge
- rst_n  input  1  reset; one clock, synchronous, active-low
- rxdv  input  1  GMII receive data valid
- rxer  input  1  GMII receive error
- datain  input  8  GMII receive byte
- ram_wr_en  output  1  payload word write strobe, one cycle per word
- ram_wr_addr  output  8  payload word address
- ram_wr_data  output  32  payload word; first byte in [31:24]
- rx_data_length  output  16  UDP length field of the last accepted header (payload + 8)
- rx_done  output  1  one-cycle pulse: frame accepted and FCS good
- rx_err  output  1  one-cycle pulse: frame aborted or FCS bad after a header match
- rx_state  output  4  current FSM state

## Operation
- Reset values: all outputs 0; rx_state = IDLE (0); CRC register 32'hFFFFFFFF.
- FSM states and encodings:
  - IDLE 0: wait for rxdv=1 with datain=8'h55; then go to PREAMBLE.
  - PREAMBLE 1: accept 8'h55 bytes.
    - 8'hD5 → MAC, with the CRC register re-initialised to FFFFFFFF.
    - Any other byte → DROP.
    - More than 7 bytes of 55 → DROP.
  - MAC 2: 14 bytes.
    - Destination must equal LOCAL_MAC or all-ones. Source is ignored.
    - EtherType must be 16'h0800.
    - On mismatch → DROP.
  - IPHDR 3: 20 bytes.
    - byte0 must be 8'h45.
    - byte9 (protocol) must be 8'h11.
    - bytes 16–19 must equal LOCAL_IP.
    - Header checksum: ten 16-bit words summed in a 20-bit accumulator, carries folded twice; the folded result must be 16'hFFFF.
    - Any failure → DROP. Pass → UDP.
  - UDP 4: 8 bytes.
    - bytes 2–3 must equal LOCAL_PORT.
    - bytes 4–5 latched into rx_data_length.
    - bytes 6–7 (UDP checksum) ignored.
    - Port mismatch → DROP.
    - Length < 8 → DROP.
    - Length == 8 → WAITEND.
    - Otherwise → DATA.
  - DATA 5: payload byte count = rx_data_length − 8.
    - Bytes pack MSB-first into a 32-bit shift register.
    - Each 4th byte writes the word.
    - After the last payload byte, a partial word is written with its unused low bytes zero.
    - Then → WAITEND.
  - WAITEND 6: absorb Ethernet pad bytes and the 4 FCS bytes until rxdv=0.
  - DROP 7: ignore input until rxdv=0, then → IDLE. No pulse.
- ram_wr_addr:
  - Cleared to 0 on entry to MAC.
  - Increments after each write; 255 wraps to 0.
  - Payloads longer than 1024 bytes overwrite from address 0.
- CRC:
  - Reflected CRC-32, polynomial 32'hEDB88320, LSB-first.
  - Updated with every byte from the first destination-MAC byte through the last FCS byte, including pad bytes.
- Frame end:
  - Checked on the first cycle with rxdv=0 while in WAITEND.
  - CRC register == 32'hDEBB20E3 → rx_done.
  - Otherwise → rx_err.
  - Either way → IDLE.
- Abort:
  - rxdv=0 while in MAC/IPHDR/UDP/DATA → IDLE, with rx_err pulsed only if the state is UDP or DATA.
  - rxer=1 in any state other than IDLE → DROP, with rx_err pulsed if the state is UDP, DATA or WAITEND.
- rxdv must drop for at least one cycle between frames. A frame starting in the cycle DROP exits is not detected.
- Payload words already written are not retracted on error. Consumers use only data framed by rx_done.

## Timing
- Byte n of a frame is sampled at rising edge n. The state changes on the same edge that samples the deciding byte.
- ram_wr_en is high in the cycle after the 4th byte of a word is sampled. ram_wr_data and ram_wr_addr are valid in that same cycle.
- A partial last word is written in the cycle after the last payload byte is sampled.
- rx_data_length is updated in the cycle after UDP byte 5 is sampled. It holds its value until the next accepted UDP header.
- rx_done / rx_err go high in the cycle after the first rxdv=0 sample and last exactly one cycle.
- rst_n=0 mid-frame:
  - All outputs return to 0 on the next edge and the state returns to IDLE.
  - The remainder of that frame is ignored until rxdv falls.
  - rx_data_length is cleared.

## Test plan
- Broadcast frame to 192.168.0.2:8080 with 16-byte payload 00..0F and a valid FCS → 4 writes at addresses 0–3: 00010203, 04050607, 08090A0B, 0C0D0E0F; rx_data_length=24; rx_done one cycle after rxdv falls.
- 5-byte payload AA BB CC DD EE, padded to a 60-byte frame → writes AABBCCDD at address 0 and EE000000 at address 1; pad bytes are not written; rx_done.
- Same frame with one FCS bit flipped → identical writes; rx_err pulse; no rx_done.
- Destination IP 192.168.0.3, or port 0x1F91, or bad IP checksum → no writes; no pulses; state returns to IDLE when rxdv falls.
- rxer asserted on payload byte 6 → DROP; rx_err pulse; no further writes. The next valid frame is received normally.
- 1100-byte payload → 275 writes; addresses wrap 255 → 0; rst_n low mid-payload clears all outputs on the next edge.
